// File: rtl/bcd_e3.sv
// Registered BCD-to-Excess-3 converter for DIGITS packed digits, with one cycle of latency.
// Define BCD_E3_ERR_COUNT_EN to add a saturating 8-bit count of words that contained an invalid digit.
module bcd_e3 #(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   e,
    output logic                  err,
    output logic [DIGITS-1:0]     err_mask
`ifdef BCD_E3_ERR_COUNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam logic [3:0] MAX_DIGIT = 4'd9;
    localparam logic [3:0] OFFSET    = 4'd3;

    logic [4*DIGITS-1:0] e_next;
    logic [DIGITS-1:0]   err_mask_next;

    // Each digit is handled on its own, so an invalid neighbour never disturbs a valid digit.
    always_comb begin
        // NOTE: defaults first so that every path assigns every bit and no latch is inferred.
        e_next        = '0;
        err_mask_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > MAX_DIGIT) begin
                err_mask_next[i] = 1'b1;
            end else begin
                e_next[4*i +: 4] = b[4*i +: 4] + OFFSET;
            end
        end
    end

    // Results load only on accepted words, so X/Z on b while in_valid is low cannot reach the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all state; all output registers reset so nothing is X after reset.
        if (!rst_n) begin
            out_valid <= 1'b0;
            e         <= '0;
            err       <= 1'b0;
            err_mask  <= '0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            e         <= e_next;
            err       <= |err_mask_next;
            err_mask  <= err_mask_next;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef BCD_E3_ERR_COUNT_EN
    // Saturating counter: it stops at 255 and only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (in_valid && (|err_mask_next) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bcd_e3.sv
// Directed self-checking bench for bcd_e3: one instance with DIGITS=1 and one with DIGITS=2.
// The err_cnt checks build only when BCD_E3_ERR_COUNT_EN is defined.
module tb_bcd_e3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid1 = 1'b0;
    logic [3:0] b1 = '0;
    logic       out_valid1;
    logic [3:0] e1;
    logic       err1;
    logic [0:0] err_mask1;

    logic       in_valid2 = 1'b0;
    logic [7:0] b2 = '0;
    logic       out_valid2;
    logic [7:0] e2;
    logic       err2;
    logic [1:0] err_mask2;

`ifdef BCD_E3_ERR_COUNT_EN
    logic [7:0] err_cnt1;
    logic [7:0] err_cnt2;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bcd_e3 #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .b         (b1),
        .out_valid (out_valid1),
        .e         (e1),
        .err       (err1),
        .err_mask  (err_mask1)
`ifdef BCD_E3_ERR_COUNT_EN
        ,
        .err_cnt   (err_cnt1)
`endif
    );

    bcd_e3 #(.DIGITS(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .b         (b2),
        .out_valid (out_valid2),
        .e         (e2),
        .err       (err2),
        .err_mask  (err_mask2)
`ifdef BCD_E3_ERR_COUNT_EN
        ,
        .err_cnt   (err_cnt2)
`endif
    );

    // Wait for the next rising edge, then settle 1 time unit before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] e1_exp;
        rst_n = 1'b0;
        #2;
        n_total++;
        if ({out_valid1, e1, err1, err_mask1} !== 7'b0) begin
            $display("FAIL reset_init_d1: got ov=%b e=%h err=%b mask=%b, want all 0",
                     out_valid1, e1, err1, err_mask1);
        end else n_pass++;
        n_total++;
        if ({out_valid2, e2, err2, err_mask2} !== 12'b0) begin
            $display("FAIL reset_init_d2: got ov=%b e=%h err=%b mask=%b, want all 0",
                     out_valid2, e2, err2, err_mask2);
        end else n_pass++;
        tick();
        rst_n = 1'b1;
        // Load a nonzero result, then assert reset mid-cycle with a word still presented.
        in_valid1 = 1'b1;
        b1 = 4'd6;
        tick();
        e1_exp = 4'h9;
        n_total++;
        if (e1 !== e1_exp || out_valid1 !== 1'b1) begin
            $display("FAIL reset_preload: got e=%h ov=%b, want e=%h ov=1", e1, out_valid1, e1_exp);
        end else n_pass++;
        b1 = 4'hB;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_valid1, e1, err1, err_mask1} !== 7'b0) begin
            $display("FAIL reset_async: got ov=%b e=%h err=%b mask=%b, want all 0 before any edge",
                     out_valid1, e1, err1, err_mask1);
        end else n_pass++;
        tick();
        n_total++;
        if ({out_valid1, e1, err1, err_mask1} !== 7'b0) begin
            $display("FAIL reset_held: got ov=%b e=%h err=%b mask=%b, want all 0",
                     out_valid1, e1, err1, err_mask1);
        end else n_pass++;
        in_valid1 = 1'b0;
        b1 = '0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sweep();
        logic [3:0] e_tab [10] = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC};
        for (int d = 0; d < 10; d++) begin
            in_valid1 = 1'b1;
            b1 = 4'(d);
            tick();
            n_total++;
            if (e1 !== e_tab[d] || out_valid1 !== 1'b1 || err1 !== 1'b0 || err_mask1 !== 1'b0) begin
                $display("FAIL sweep_%0d: got e=%h ov=%b err=%b mask=%b, want e=%h ov=1 err=0 mask=0",
                         d, e1, out_valid1, err1, err_mask1, e_tab[d]);
            end else n_pass++;
        end
        in_valid1 = 1'b0;
        tick();
    endtask

    task automatic test_invalid();
        for (int d = 10; d < 16; d++) begin
            in_valid1 = 1'b1;
            b1 = 4'(d);
            tick();
            n_total++;
            if (e1 !== 4'h0 || out_valid1 !== 1'b1 || err1 !== 1'b1 || err_mask1 !== 1'b1) begin
                $display("FAIL invalid_%0d: got e=%h ov=%b err=%b mask=%b, want e=0 ov=1 err=1 mask=1",
                         d, e1, out_valid1, err1, err_mask1);
            end else n_pass++;
        end
        // A valid word afterwards must clear the error flags again.
        b1 = 4'd0;
        tick();
        n_total++;
        if (e1 !== 4'h3 || err1 !== 1'b0 || err_mask1 !== 1'b0) begin
            $display("FAIL invalid_recover: got e=%h err=%b mask=%b, want e=3 err=0 mask=0",
                     e1, err1, err_mask1);
        end else n_pass++;
        in_valid1 = 1'b0;
        tick();
    endtask

    task automatic test_multi_digit();
        in_valid2 = 1'b1;
        b2 = 8'h95;
        tick();
        n_total++;
        if (e2 !== 8'hC8 || out_valid2 !== 1'b1 || err2 !== 1'b0 || err_mask2 !== 2'b00) begin
            $display("FAIL multi_95: got e=%h ov=%b err=%b mask=%b, want e=c8 ov=1 err=0 mask=00",
                     e2, out_valid2, err2, err_mask2);
        end else n_pass++;
        b2 = 8'hA7;
        tick();
        n_total++;
        if (e2 !== 8'h0A || out_valid2 !== 1'b1 || err2 !== 1'b1 || err_mask2 !== 2'b10) begin
            $display("FAIL multi_a7: got e=%h ov=%b err=%b mask=%b, want e=0a ov=1 err=1 mask=10",
                     e2, out_valid2, err2, err_mask2);
        end else n_pass++;
        b2 = 8'h3F;
        tick();
        n_total++;
        if (e2 !== 8'h60 || err2 !== 1'b1 || err_mask2 !== 2'b01) begin
            $display("FAIL multi_3f: got e=%h err=%b mask=%b, want e=60 err=1 mask=01",
                     e2, err2, err_mask2);
        end else n_pass++;
        b2 = 8'hA7;
        tick();
        // Hold with X on b: outputs must keep the last accepted result.
        in_valid2 = 1'b0;
        b2 = 'x;
        tick();
        n_total++;
        if (out_valid2 !== 1'b0 || e2 !== 8'h0A || err2 !== 1'b1 || err_mask2 !== 2'b10) begin
            $display("FAIL multi_hold: got ov=%b e=%h err=%b mask=%b, want ov=0 e=0a err=1 mask=10",
                     out_valid2, e2, err2, err_mask2);
        end else n_pass++;
        tick();
        n_total++;
        if (out_valid2 !== 1'b0 || e2 !== 8'h0A) begin
            $display("FAIL multi_hold2: got ov=%b e=%h, want ov=0 e=0a", out_valid2, e2);
        end else n_pass++;
        b2 = '0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] e_exp [3] = '{4'h3, 4'h4, 4'h5};
        for (int k = 0; k < 3; k++) begin
            in_valid1 = 1'b1;
            b1 = 4'(k);
            tick();
            n_total++;
            if (e1 !== e_exp[k] || out_valid1 !== 1'b1) begin
                $display("FAIL b2b_%0d: got e=%h ov=%b, want e=%h ov=1", k, e1, out_valid1, e_exp[k]);
            end else n_pass++;
        end
        in_valid1 = 1'b0;
        b1 = 'x;
        tick();
        n_total++;
        if (out_valid1 !== 1'b0 || e1 !== 4'h5) begin
            $display("FAIL b2b_end: got ov=%b e=%h, want ov=0 e=5", out_valid1, e1);
        end else n_pass++;
        b1 = '0;
    endtask

`ifdef BCD_E3_ERR_COUNT_EN
    task automatic test_err_count();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        n_total++;
        if (err_cnt1 !== 8'd0) begin
            $display("FAIL cnt_reset: got %0d, want 0", err_cnt1);
        end else n_pass++;
        in_valid1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b1 = (k == 2) ? 4'd5 : 4'hC;
            if (k == 3) b1 = 4'hA;
            tick();
        end
        in_valid1 = 1'b0;
        b1 = 4'hF;
        tick();
        n_total++;
        if (err_cnt1 !== 8'd3) begin
            $display("FAIL cnt_three: got %0d, want 3", err_cnt1);
        end else n_pass++;
        in_valid1 = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
        end
        in_valid1 = 1'b0;
        tick();
        n_total++;
        if (err_cnt1 !== 8'd255) begin
            $display("FAIL cnt_saturate: got %0d, want 255", err_cnt1);
        end else n_pass++;
        b1 = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_invalid();
        test_multi_digit();
        test_back_to_back();
`ifdef BCD_E3_ERR_COUNT_EN
        test_err_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_e3.md
Name: bcd_e3

Overview:
- Registered BCD-to-Excess-3 code converter for one or more packed BCD digits.
- Each valid digit is converted as Excess-3 = BCD + 3.
- Non-decimal codes (1010–1111) are flagged as errors.
- Sits in the datapath between BCD producers (counters, keypad decoders) and Excess-3 consumers (self-complementing adders, display logic).
- One clock. Asynchronous active-low reset.

Parameters:
- DIGITS, 1, number of packed BCD digits converted in parallel (legal range 1–8).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  b holds a word to convert this cycle.
- b  input  4*DIGITS  packed BCD digits; digit i is b[4i+3:4i], digit 0 least significant.
- out_valid  output  1  e, err and err_mask are updated this cycle.
- e  output  4*DIGITS  packed Excess-3 digits, same ordering as b.
- err  output  1  OR of err_mask; at least one digit of the last accepted word was invalid.
- err_mask  output  DIGITS  bit i set when digit i of the last accepted word was greater than 9.

Behaviour:
- Reset (rst_n low, asynchronous, held while low):
  - e = 0, out_valid = 0, err = 0, err_mask = 0.
  - Release is synchronous to the next clk edge in effect; the first capture occurs on the first rising edge with rst_n high.
- Latency: 1 cycle. A word presented with in_valid high at edge N appears on e with out_valid high after edge N.
- in_valid high at a rising edge:
  - Valid digit (value 0–9): e digit <= b digit + 3, modulo-4-bit add. Mapping: 0000->0011, 0001->0100, 0010->0101, 0011->0110, 0100->0111, 0101->1000, 0110->1001, 0111->1010, 1000->1011, 1001->1100.
  - Invalid digit (1010–1111): e digit <= 0000 and err_mask bit i <= 1.
  - Each digit is converted independently; a neighbouring invalid digit does not affect a valid one.
  - out_valid <= 1. err <= |err_mask_next.
- in_valid low at a rising edge:
  - out_valid <= 0.
  - e, err and err_mask hold their last values.
- No backpressure: a new word may be accepted every cycle (full throughput), and each accept overwrites the previous result.
- Outputs are pure registers; no combinational path from b or in_valid to any output.
- Reset asserted mid-stream: all outputs clear immediately; any word in flight is discarded.
- X/Z on b while in_valid is low must not propagate to the outputs.

Optional Feature:
- Macro: BCD_E3_ERR_COUNT_EN.
- Defined:
  - Adds output err_cnt, 8 bits, reset to 0.
  - Increments by 1 on every accepted word (in_valid high) with err = 1 next.
  - Saturates at 255 and never wraps.
  - Cleared only by rst_n.
- Undefined: err_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-operation -> e=0, out_valid=0, err=0 immediately, without waiting for a clk edge.
- Full sweep, DIGITS=1: b=0000..1001 in consecutive cycles with in_valid=1 -> one cycle later e=0011..1100 respectively; out_valid=1 and err=0 throughout.
- Invalid codes, DIGITS=1: b=1010..1111 -> e=0000, err=1, err_mask=1 for each.
- Multi-digit and hold, DIGITS=2:
  - b=8'h95 -> e=8'hC8, err=0.
  - b=8'hA7 -> e=8'h0A, err_mask=2'b10.
  - Then in_valid=0 -> out_valid=0 while e holds 8'h0A.
- Back-to-back streaming, DIGITS=1: b=0,1,2 on three consecutive cycles -> e=3,4,5 on the following three cycles with out_valid continuously high.
- BCD_E3_ERR_COUNT_EN defined:
  - Three invalid words and one valid word -> err_cnt=3.
  - 300 invalid words -> err_cnt=255, saturated.
